ysyx_23060240_csr_ctrl: RTL and testbench

CSR access initiator for the ysyx_23060240 core, sitting between the decode/execute stage and the CSR register file. It accepts one decoded Zicsr or trap instruction per request and sequences the read, then the optional write, on the CSR file's read/write ports. For `ecall` and `mret` it raises the trap/return strobes and returns the redirect target. The result goes to writeback over a valid/ready pair.

---
 rtl/ysyx_23060240_csr_pkg.sv | 39 +++
 rtl/ysyx_23060240_csr_ctrl_if.sv | 55 +++++
 rtl/ysyx_23060240_csr_alu.sv | 27 ++
 rtl/ysyx_23060240_csr_ctrl.sv | 123 ++++++++++++
 tb/tb_ysyx_23060240_csr_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060240_csr_pkg.sv
// ysyx_23060240_csr_pkg
// Shared definitions for the CSR access path: opcode encodings (also used by
// decode), machine-mode CSR addresses, controller FSM states and the latched
// request record.
package ysyx_23060240_csr_pkg;

  localparam int CSR_XLEN   = 32;
  localparam int CSR_ADDR_W = 12;

  localparam logic [2:0] OP_CSRRW  = 3'd0;
  localparam logic [2:0] OP_CSRRS  = 3'd1;
  localparam logic [2:0] OP_CSRRC  = 3'd2;
  localparam logic [2:0] OP_CSRRWI = 3'd3;
  localparam logic [2:0] OP_CSRRSI = 3'd4;
  localparam logic [2:0] OP_CSRRCI = 3'd5;
  localparam logic [2:0] OP_ECALL  = 3'd6;
  localparam logic [2:0] OP_MRET   = 3'd7;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_state_e;

  typedef struct packed {
    logic [2:0]            op;
    logic [CSR_ADDR_W-1:0] csr;
    logic [CSR_XLEN-1:0]   src;
    logic                  zero_src;  // rs1 index 0 / zimm 0
    logic [CSR_XLEN-1:0]   pc;
  } csr_req_t;

endpackage

// File: rtl/ysyx_23060240_csr_ctrl_if.sv
// ysyx_23060240_csr_ctrl_if
// Bundles the request (decode), response (writeback) and CSR-file port signals
// of the CSR controller.
//   slave  : the controller side (takes requests, drives CSR ports/responses)
//   master : everything around it (decode, writeback, CSR file)
interface ysyx_23060240_csr_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [CSR_AW-1:0] req_csr;
  logic [4:0]        req_rs1_idx;
  logic [XLEN-1:0]   req_rs1;
  logic [4:0]        req_zimm;
  logic [XLEN-1:0]   req_pc;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rd_data;
  logic              resp_redirect;
  logic [XLEN-1:0]   resp_redirect_pc;

  logic [XLEN-1:0]   csr_pc;
  logic              r_csr_en;
  logic [CSR_AW-1:0] r_csr_addr;
  logic [XLEN-1:0]   r_csr_data;
  logic              w_csr_en;
  logic [CSR_AW-1:0] w_csr_addr;
  logic [XLEN-1:0]   w_csr_data;
  logic              jump_ecall;
  logic              jump_mret;

  modport slave (
    input  req_valid, req_op, req_csr, req_rs1_idx, req_rs1, req_zimm, req_pc,
    output req_ready,
    output resp_valid, resp_rd_data, resp_redirect, resp_redirect_pc,
    input  resp_ready,
    output csr_pc, r_csr_en, r_csr_addr, w_csr_en, w_csr_addr, w_csr_data,
    output jump_ecall, jump_mret,
    input  r_csr_data
  );

  modport master (
    output req_valid, req_op, req_csr, req_rs1_idx, req_rs1, req_zimm, req_pc,
    input  req_ready,
    input  resp_valid, resp_rd_data, resp_redirect, resp_redirect_pc,
    output resp_ready,
    input  csr_pc, r_csr_en, r_csr_addr, w_csr_en, w_csr_addr, w_csr_data,
    input  jump_ecall, jump_mret,
    output r_csr_data
  );

endinterface

// File: rtl/ysyx_23060240_csr_alu.sv
// ysyx_23060240_csr_alu
// Combinational read-modify function for Zicsr writes.
//   op      : request opcode (register and immediate forms share behaviour)
//   old_val : CSR value read earlier
//   src     : rs1 value or zero-extended zimm
//   new_val : value to write back (RW: src, RS: old|src, RC: old&~src)
module ysyx_23060240_csr_alu
  import ysyx_23060240_csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = src;
    unique case (op)
      OP_CSRRS, OP_CSRRSI: new_val = old_val | src;
      OP_CSRRC, OP_CSRRCI: new_val = old_val & ~src;
      default:             new_val = src;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_csr_ctrl.sv
// ysyx_23060240_csr_ctrl
// Sequences one Zicsr / ECALL / MRET request onto the CSR file: READ, then an
// optional WRITE, then a held RESP to writeback. ECALL reads mtvec and MRET
// reads mepc; the value read becomes the redirect target.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   io       : request / response / CSR-file signals (slave modport)
// Build option:
//   YSYX_CSR_WSKIP_EN - set/clear forms with a zero source skip the WRITE cycle.
module ysyx_23060240_csr_ctrl
  import ysyx_23060240_csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_23060240_csr_ctrl_if.slave io
);

`ifdef YSYX_CSR_WSKIP_EN
  localparam bit WSKIP_EN = 1'b1;
`else
  localparam bit WSKIP_EN = 1'b0;
`endif

  csr_state_e        state_q, state_d;
  csr_req_t          req_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   src_d;
  logic [XLEN-1:0]   wdata;
  logic [CSR_AW-1:0] rd_addr;
  logic              accept, is_imm, zero_d, is_trap, skip_wr;

  // Gated by rst so every output reads 0 while reset is held.
  assign io.req_ready = (state_q == ST_IDLE) && !rst;
  assign accept       = io.req_valid && io.req_ready;

  assign is_imm  = io.req_op inside {OP_CSRRWI, OP_CSRRSI, OP_CSRRCI};
  assign src_d   = is_imm ? {{(XLEN-5){1'b0}}, io.req_zimm} : io.req_rs1;
  assign zero_d  = is_imm ? (io.req_zimm == 5'd0) : (io.req_rs1_idx == 5'd0);
  assign is_trap = req_q.op inside {OP_ECALL, OP_MRET};
  // Write forms always write; only set/clear with a zero source may skip.
  assign skip_wr = WSKIP_EN && req_q.zero_src &&
                   !(req_q.op inside {OP_CSRRW, OP_CSRRWI});

  always_comb begin
    rd_addr = req_q.csr;
    if (req_q.op == OP_ECALL)     rd_addr = CSR_MTVEC;
    else if (req_q.op == OP_MRET) rd_addr = CSR_MEPC;
  end

  ysyx_23060240_csr_alu #(.XLEN(XLEN)) u_alu (
    .op      (req_q.op),
    .old_val (old_q),
    .src     (req_q.src),
    .new_val (wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.op       <= io.req_op;
        req_q.csr      <= io.req_csr;
        req_q.src      <= src_d;
        req_q.zero_src <= zero_d;
        req_q.pc       <= io.req_pc;
      end
      if (state_q == ST_READ) old_q <= io.r_csr_data;
    end
  end

  // Strobes are decoded straight from state so they span the whole state
  // cycle, letting the CSR file sample on the falling edge.
  always_comb begin
    state_d             = state_q;
    io.r_csr_en         = 1'b0;
    io.r_csr_addr       = '0;
    io.w_csr_en         = 1'b0;
    io.w_csr_addr       = '0;
    io.w_csr_data       = '0;
    io.csr_pc           = '0;
    io.jump_ecall       = 1'b0;
    io.jump_mret        = 1'b0;
    io.resp_valid       = 1'b0;
    io.resp_rd_data     = '0;
    io.resp_redirect    = 1'b0;
    io.resp_redirect_pc = '0;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: begin
        io.r_csr_en   = 1'b1;
        io.r_csr_addr = rd_addr;
        io.csr_pc     = req_q.pc;
        io.jump_ecall = (req_q.op == OP_ECALL);
        io.jump_mret  = (req_q.op == OP_MRET);
        state_d       = (is_trap || skip_wr) ? ST_RESP : ST_WRITE;
      end
      ST_WRITE: begin
        io.w_csr_en   = 1'b1;
        io.w_csr_addr = req_q.csr;
        io.w_csr_data = wdata;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        io.resp_valid   = 1'b1;
        io.resp_rd_data = old_q;
        if (is_trap) begin
          io.resp_redirect    = 1'b1;
          io.resp_redirect_pc = old_q;
        end
        if (io.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060240_csr_ctrl.sv
module tb_ysyx_23060240_csr_ctrl;
  import ysyx_23060240_csr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060240_csr_ctrl_if #(.XLEN(32), .CSR_AW(12)) bus ();
  ysyx_23060240_csr_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // CSR file model: combinational read, falling-edge write.
  logic [31:0] csr_mem [0:4095];
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;
  always @(negedge clk) begin
    if (poke_en)           csr_mem[poke_addr] <= poke_data;
    else if (bus.w_csr_en) csr_mem[bus.w_csr_addr] <= bus.w_csr_data;
  end
  assign bus.r_csr_data = csr_mem[bus.r_csr_addr];

  typedef struct {
    logic [31:0] rd;
    logic [31:0] redir;
    logic [31:0] rpc;
    logic [31:0] wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] lat;
    logic [31:0] raddr;
    logic [31:0] n_ecall;
    logic [31:0] n_mret;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic [31:0] redir,
                              input logic [31:0] rpc, input logic [31:0] wen,
                              input logic [31:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] lat, input logic [31:0] raddr,
                              input logic [31:0] ne, input logic [31:0] nm);
    exp_t e;
    e.rd = rd; e.redir = redir; e.rpc = rpc; e.wen = wen; e.waddr = waddr;
    e.wdata = wdata; e.lat = lat; e.raddr = raddr; e.n_ecall = ne; e.n_mret = nm;
    return e;
  endfunction

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(negedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [11:0] csr,
                           input logic [4:0] idx, input logic [31:0] rs1,
                           input logic [4:0] zimm, input logic [31:0] pc);
    int w;
    w = 0;
    while (!bus.req_ready && w < 10) begin @(posedge clk); #1; w++; end
    check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_csr = csr; bus.req_rs1_idx = idx;
    bus.req_rs1 = rs1; bus.req_zimm = zimm; bus.req_pc = pc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // One full transaction; hold = extra RESP cycles with resp_ready low.
  task automatic run_op(input logic [2:0] op, input logic [11:0] csr,
                        input logic [4:0] idx, input logic [31:0] rs1,
                        input logic [4:0] zimm, input logic [31:0] pc,
                        input exp_t e, input int hold);
    int cyc, n_w, n_e, n_m;
    logic [31:0] wd, wa;
    exp_t x;
    sb.push_back(e);
    drive_req(op, csr, idx, rs1, zimm, pc);
    x = sb.pop_front();
    // now in the cycle after accept: READ
    check("read_en", 32'(bus.r_csr_en), 32'd1);
    check("read_addr", 32'(bus.r_csr_addr), x.raddr);
    check("csr_pc", bus.csr_pc, pc);
    cyc = 1; n_w = 0; n_e = 0; n_m = 0; wd = '0; wa = '0;
    while (!bus.resp_valid && cyc < 10) begin
      if (bus.w_csr_en) begin n_w++; wd = bus.w_csr_data; wa = 32'(bus.w_csr_addr); end
      if (bus.jump_ecall) n_e++;
      if (bus.jump_mret)  n_m++;
      @(posedge clk); #1; cyc++;
    end
    check("resp_latency", 32'(cyc), x.lat);
    check("write_cycles", 32'(n_w), x.wen);
    if (x.wen != 0) begin
      check("write_addr", wa, x.waddr);
      check("write_data", wd, x.wdata);
    end
    check("ecall_cycles", 32'(n_e), x.n_ecall);
    check("mret_cycles", 32'(n_m), x.n_mret);
    check("rd_data", bus.resp_rd_data, x.rd);
    check("redirect", 32'(bus.resp_redirect), x.redir);
    check("redirect_pc", bus.resp_redirect_pc, x.rpc);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_rd_data", bus.resp_rd_data, x.rd);
      check("hold_redirect_pc", bus.resp_redirect_pc, x.rpc);
      check("hold_no_strobe", 32'(bus.jump_mret | bus.jump_ecall | bus.w_csr_en), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_dropped", 32'(bus.resp_valid), 32'd0);
    check("ready_after_resp", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_csr = '0; bus.req_rs1_idx = '0;
    bus.req_rs1 = '0; bus.req_zimm = '0; bus.req_pc = '0; bus.resp_ready = 1'b0;
    poke(CSR_MSTATUS, 32'h0000_1800);
    poke(CSR_MTVEC,   32'h0000_0000);
    poke(CSR_MEPC,    32'h8000_0044);
    poke(CSR_MCAUSE,  32'h0000_0000);

    // reset state
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_enables", 32'({bus.r_csr_en, bus.w_csr_en, bus.jump_ecall, bus.jump_mret}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", 32'(bus.req_ready), 32'd1);

    // CSRRW mtvec
    run_op(OP_CSRRW, CSR_MTVEC, 5'd1, 32'h8000_0100, 5'd0, 32'h8000_0000,
           mk(32'h0, 0, 32'h0, 1, 32'h305, 32'h8000_0100, 3, 32'h305, 0, 0), 0);
    // CSRRS mstatus |= 8
    run_op(OP_CSRRS, CSR_MSTATUS, 5'd2, 32'h0000_0008, 5'd0, 32'h8000_0004,
           mk(32'h1800, 0, 32'h0, 1, 32'h300, 32'h1808, 3, 32'h300, 0, 0), 0);
    // CSRRCI with zimm=0
`ifdef YSYX_CSR_WSKIP_EN
    e = mk(32'h1808, 0, 32'h0, 0, 32'h0, 32'h0, 2, 32'h300, 0, 0);
`else
    e = mk(32'h1808, 0, 32'h0, 1, 32'h300, 32'h1808, 3, 32'h300, 0, 0);
`endif
    run_op(OP_CSRRCI, CSR_MSTATUS, 5'd0, 32'h0, 5'd0, 32'h8000_0008, e, 0);
    // CSRRC with nonzero source always writes
    run_op(OP_CSRRC, CSR_MSTATUS, 5'd3, 32'h0000_0008, 5'd0, 32'h8000_000c,
           mk(32'h1808, 0, 32'h0, 1, 32'h300, 32'h1800, 3, 32'h300, 0, 0), 0);
    // CSRRS with rs1 index 0 (value ignored only for the skip decision)
`ifdef YSYX_CSR_WSKIP_EN
    e = mk(32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 2, 32'h342, 0, 0);
`else
    e = mk(32'h0, 0, 32'h0, 1, 32'h342, 32'h0000_ffff, 3, 32'h342, 0, 0);
`endif
    run_op(OP_CSRRS, CSR_MCAUSE, 5'd0, 32'h0000_ffff, 5'd0, 32'h8000_0010, e, 0);

    // ECALL
    poke(CSR_MTVEC, 32'h8000_0200);
    run_op(OP_ECALL, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0040,
           mk(32'h8000_0200, 1, 32'h8000_0200, 0, 32'h0, 32'h0, 2, 32'h305, 1, 0), 0);
    // MRET with resp_ready low for 3 cycles
    run_op(OP_MRET, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0300,
           mk(32'h8000_0044, 1, 32'h8000_0044, 0, 32'h0, 32'h0, 2, 32'h341, 0, 1), 3);
    // CSRRWI mepc
    run_op(OP_CSRRWI, CSR_MEPC, 5'd0, 32'h0, 5'd21, 32'h8000_0014,
           mk(32'h8000_0044, 0, 32'h0, 1, 32'h341, 32'h0000_0015, 3, 32'h341, 0, 0), 0);

    // reset during WRITE of CSRRW
    drive_req(OP_CSRRW, CSR_MEPC, 5'd7, 32'hdead_beef, 5'd0, 32'h8000_0018);
    @(posedge clk); #1;
    check("pre_reset_write_en", 32'(bus.w_csr_en), 32'd1);
    rst = 1'b1;
    #1;
    check("reset_write_drop", 32'(bus.w_csr_en), 32'd0);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_midop_reset", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_resp_after_reset", 32'(bus.resp_valid), 32'd0);
    end
    check("mepc_not_written", csr_mem[12'h341], 32'h0000_0015);

    // recovery after mid-op reset
    run_op(OP_CSRRS, CSR_MEPC, 5'd4, 32'h0000_0100, 5'd0, 32'h8000_001c,
           mk(32'h15, 0, 32'h0, 1, 32'h341, 32'h0000_0115, 3, 32'h341, 0, 0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
